// File: rtl/ddr_timing_pkg.sv
// Shared DDR4 timing defaults, refresh FSM encoding and widths.
package ddr_timing_pkg;

  localparam int DefTRefi       = 7800;
  localparam int DefTRfc        = 350;
  localparam int DefTRp         = 14;
  localparam int DefMaxPostpone = 8;
  localparam int DefMaxPullin   = 8;
  localparam int DefCntW        = 16;

  // Open-row bitmap: bit = bg*4 + bank.
  localparam int BankW = 16;
  // Signed owed-refresh count, range -MAX_PULLIN..MAX_POSTPONE+1.
  localparam int DebtW = 5;

  typedef enum logic [2:0] {
    StIdle,
    StDrain,
    StPrech,
    StWaitRp,
    StRef,
    StWaitRfc
  } ref_state_e;

endpackage

// File: rtl/refresh_scheduler_if.sv
// Refresh scheduler <-> command arbiter / host-side status bundle.
interface refresh_scheduler_if;
  import ddr_timing_pkg::*;

  logic                    enable;
  logic                    pullin_en;
  logic                    bus_idle;
  logic [BankW-1:0]        banks_open;
  logic                    pre_req;
  logic                    pre_ack;
  logic                    ref_req;
  logic                    ref_ack;
  logic                    hold_traffic;
  logic                    urgent;
  logic                    refresh_done;
  logic signed [DebtW-1:0] debt;
  logic                    err_overflow;

  // Scheduler side.
  modport master (
    input  enable, pullin_en, bus_idle, banks_open, pre_ack, ref_ack,
    output pre_req, ref_req, hold_traffic, urgent, refresh_done, debt, err_overflow
  );

  // Arbiter side.
  modport slave (
    output enable, pullin_en, bus_idle, banks_open, pre_ack, ref_ack,
    input  pre_req, ref_req, hold_traffic, urgent, refresh_done, debt, err_overflow
  );

endinterface

// File: rtl/refresh_timebase.sv
// tREFI timebase: counts 0..T_REFI-1 and flags the wrap cycle.
module refresh_timebase #(
  parameter int T_REFI = 7800,
  parameter int CNT_W  = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Wrap detection and next count.
  always_comb begin
    tick_o = (cnt_q == CNT_W'(T_REFI - 1));
    cnt_d  = tick_o ? '0 : cnt_q + CNT_W'(1);
  end

  // Free-running counter, independent of enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/refresh_scheduler.sv
// All-bank refresh scheduler: debt tracking, postpone/pull-in policy and
// the precharge-all / REF handshake sequence toward the command arbiter.
module refresh_scheduler
  import ddr_timing_pkg::*;
#(
  parameter int T_REFI       = DefTRefi,
  parameter int T_RFC        = DefTRfc,
  parameter int T_RP         = DefTRp,
  parameter int MAX_POSTPONE = DefMaxPostpone,
  parameter int MAX_PULLIN   = DefMaxPullin,
  parameter int CNT_W        = DefCntW
) (
  input logic                 sys_clk,
  input logic                 sys_rst_n,
  refresh_scheduler_if.master bus_io
);

  localparam logic signed [DebtW-1:0] DebtHi    = DebtW'(MAX_POSTPONE + 1);
  localparam logic signed [DebtW-1:0] DebtForce = DebtW'(MAX_POSTPONE);
  localparam logic signed [DebtW-1:0] DebtLo    = DebtW'(-MAX_PULLIN);
  localparam logic signed [DebtW-1:0] DebtZero  = '0;
  localparam logic signed [DebtW-1:0] DebtOne   = DebtW'(1);

  logic                    tick;
  logic                    start;
  logic                    done;
  logic                    pre_req;
  logic                    ref_req;
  ref_state_e              state_q, state_d;
  logic [CNT_W-1:0]        tmr_q, tmr_d;
  logic signed [DebtW-1:0] debt_q, debt_d;
  logic                    err_q, err_d;

  refresh_timebase #(
    .T_REFI (T_REFI),
    .CNT_W  (CNT_W)
  ) u_timebase (
    .clk_i  (sys_clk),
    .rst_ni (sys_rst_n),
    .tick_o (tick)
  );

  // Start policy: forced when postponement is exhausted, otherwise opportunistic on idle bus.
  always_comb begin
    start = bus_io.enable &&
            ((debt_q >= DebtForce) ||
             (bus_io.bus_idle && (debt_q > DebtZero)) ||
             (bus_io.pullin_en && bus_io.bus_idle && (debt_q > DebtLo)));
  end

  // Sequence FSM; tmr is shared by tRP and tRFC since they never overlap.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    pre_req = 1'b0;
    ref_req = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StDrain;
      end
      StDrain: begin
        if (bus_io.bus_idle) state_d = (|bus_io.banks_open) ? StPrech : StRef;
      end
      StPrech: begin
        pre_req = 1'b1;
        if (bus_io.pre_ack) begin
          state_d = StWaitRp;
          // The ack cycle counts toward tRP, so REF rises exactly T_RP cycles after it.
          tmr_d   = CNT_W'(T_RP - 1);
        end
      end
      StWaitRp: begin
        if (tmr_q <= CNT_W'(1)) state_d = StRef;
        else                    tmr_d   = tmr_q - CNT_W'(1);
      end
      StRef: begin
        ref_req = 1'b1;
        if (bus_io.ref_ack) begin
          state_d = StWaitRfc;
          tmr_d   = CNT_W'(T_RFC);
        end
      end
      StWaitRfc: begin
        if (tmr_q <= CNT_W'(1)) begin
          done    = 1'b1;
          state_d = StIdle;
        end else begin
          tmr_d = tmr_q - CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Debt: +1 per tick, -1 per completion, saturating; tick at the ceiling flags overflow.
  always_comb begin
    debt_d = debt_q;
    err_d  = err_q;
    if (tick && (debt_q == DebtHi)) err_d = 1'b1;
    if (tick && !done) begin
      if (debt_q < DebtHi) debt_d = debt_q + DebtOne;
    end else if (done && !tick) begin
      if (debt_q > DebtLo) debt_d = debt_q - DebtOne;
    end
  end

  // State registers; reset aborts any sequence in flight.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
      tmr_q   <= '0;
      debt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      debt_q  <= debt_d;
      err_q   <= err_d;
    end
  end

  assign bus_io.pre_req      = pre_req;
  assign bus_io.ref_req      = ref_req;
  assign bus_io.hold_traffic = (state_q != StIdle);
  assign bus_io.urgent       = (debt_q >= DebtForce);
  assign bus_io.refresh_done = done;
  assign bus_io.debt         = debt_q;
  assign bus_io.err_overflow = err_q;

endmodule

// File: tb/tb_refresh_scheduler.sv
// Bench for refresh_scheduler: scripted scenarios plus an arbiter model whose
// acks push expected completion / REF-rise cycles onto scoreboard queues.
module tb_refresh_scheduler;

  localparam int T_REFI = 200;
  localparam int T_RFC  = 8;
  localparam int T_RP   = 5;

  logic        sys_clk;
  logic        sys_rst_n;
  int unsigned cyc;
  int unsigned rel;
  int          n_cmp;
  int          n_err;
  int          done_cnt;
  bit          ack_en;
  int          pre_delay;
  int unsigned done_q[$];
  int unsigned rp_q[$];

  refresh_scheduler_if bif();

  refresh_scheduler #(
    .T_REFI       (T_REFI),
    .T_RFC        (T_RFC),
    .T_RP         (T_RP),
    .MAX_POSTPONE (8),
    .MAX_PULLIN   (8),
    .CNT_W        (16)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus_io    (bif)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Arbiter model: acks requests and records when the DUT must respond.
  initial begin : responder
    int pre_wait;
    pre_wait = 0;
    forever begin
      @(negedge sys_clk);
      bif.pre_ack = 1'b0;
      bif.ref_ack = 1'b0;
      if (!sys_rst_n) pre_wait = 0;
      else if (ack_en) begin
        if (bif.pre_req) begin
          if (pre_wait == pre_delay) begin
            bif.pre_ack = 1'b1;
            rp_q.push_back(cyc + T_RP);
            pre_wait = 0;
          end else begin
            pre_wait++;
          end
        end
        if (bif.ref_req) begin
          bif.ref_ack = 1'b1;
          done_q.push_back(cyc + T_RFC);
        end
      end
    end
  end

  // Scoreboard: pop expectations when refresh_done pulses or ref_req rises.
  initial begin : monitor
    bit          ref_prev;
    int unsigned exp_c;
    ref_prev = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        ref_prev = 1'b0;
      end else begin
        if (bif.refresh_done === 1'b1) begin
          done_cnt++;
          n_cmp++;
          if (done_q.size() == 0) begin
            n_err++;
            $display("FAIL done_sched: refresh_done at cycle %0d, none expected", cyc);
          end else begin
            exp_c = done_q.pop_front();
            if (cyc !== exp_c) begin
              n_err++;
              $display("FAIL done_sched: refresh_done at cycle %0d, expected %0d", cyc, exp_c);
            end
          end
        end
        if (bif.ref_req === 1'b1 && !ref_prev && rp_q.size() != 0) begin
          exp_c = rp_q.pop_front();
          n_cmp++;
          if (cyc !== exp_c) begin
            n_err++;
            $display("FAIL trp_sched: ref_req rose at cycle %0d, expected %0d", cyc, exp_c);
          end
        end
        ref_prev = (bif.ref_req === 1'b1);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic wait_cyc(input int unsigned target);
    while (cyc < target) @(negedge sys_clk);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    done_q.delete();
    rp_q.delete();
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    rel = cyc;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sys_clk);
    n_cmp++;
    if ({bif.pre_req, bif.ref_req, bif.hold_traffic, bif.urgent, bif.refresh_done,
         bif.err_overflow} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outs: got %b want 000000", {bif.pre_req, bif.ref_req,
               bif.hold_traffic, bif.urgent, bif.refresh_done, bif.err_overflow});
    end
    n_cmp++;
    if (bif.debt !== 5'sd0) begin
      n_err++;
      $display("FAIL reset_debt: got %0d want 0", bif.debt);
    end
  endtask

  task automatic test_first_tick();
    bif.enable = 1'b1; bif.pullin_en = 1'b0; bif.bus_idle = 1'b1; bif.banks_open = '0;
    do_reset();
    wait_cyc(rel + T_REFI - 1);
    n_cmp++;
    if (bif.debt !== 5'sd0) begin
      n_err++; $display("FAIL pre_tick_debt: got %0d want 0", bif.debt);
    end
    wait_cyc(rel + T_REFI);
    n_cmp++;
    if (bif.debt !== 5'sd1 || bif.hold_traffic !== 1'b0) begin
      n_err++;
      $display("FAIL tick_debt: got debt %0d hold %b want 1/0", bif.debt, bif.hold_traffic);
    end
    wait_cyc(rel + T_REFI + 1);
    n_cmp++;
    if (bif.hold_traffic !== 1'b1) begin
      n_err++; $display("FAIL hold_after_start: got %b want 1", bif.hold_traffic);
    end
    wait_cyc(rel + T_REFI + 2);
    n_cmp++;
    if (bif.ref_req !== 1'b1 || bif.pre_req !== 1'b0) begin
      n_err++;
      $display("FAIL skip_prech: got ref %b pre %b want 1/0", bif.ref_req, bif.pre_req);
    end
    wait_cyc(rel + T_REFI + 2 + T_RFC + 1);
    n_cmp++;
    if (bif.debt !== 5'sd0 || bif.hold_traffic !== 1'b0) begin
      n_err++;
      $display("FAIL after_ref: got debt %0d hold %b want 0/0", bif.debt, bif.hold_traffic);
    end
  endtask

  task automatic test_postpone();
    int base;
    bif.enable = 1'b1; bif.pullin_en = 1'b0; bif.bus_idle = 1'b0; bif.banks_open = '0;
    do_reset();
    wait_cyc(rel + 8 * T_REFI - 1);
    n_cmp++;
    if (bif.debt !== 5'sd7 || bif.urgent !== 1'b0) begin
      n_err++; $display("FAIL debt7: got debt %0d urgent %b want 7/0", bif.debt, bif.urgent);
    end
    wait_cyc(rel + 8 * T_REFI);
    n_cmp++;
    if (bif.debt !== 5'sd8 || bif.urgent !== 1'b1) begin
      n_err++; $display("FAIL debt8: got debt %0d urgent %b want 8/1", bif.debt, bif.urgent);
    end
    wait_cyc(rel + 8 * T_REFI + 1);
    n_cmp++;
    if (bif.hold_traffic !== 1'b1 || bif.ref_req !== 1'b0) begin
      n_err++;
      $display("FAIL forced_drain: got hold %b ref %b want 1/0", bif.hold_traffic, bif.ref_req);
    end
    base = done_cnt;
    bif.bus_idle = 1'b1;
    wait_cyc(rel + 8 * T_REFI + 2 + T_RFC + 1);
    n_cmp++;
    if (bif.debt !== 5'sd7 || bif.urgent !== 1'b0) begin
      n_err++; $display("FAIL first_drain: got debt %0d urgent %b want 7/0", bif.debt, bif.urgent);
    end
    for (int i = 0; i < 150 && bif.debt !== 5'sd0; i++) @(negedge sys_clk);
    n_cmp++;
    if (bif.debt !== 5'sd0 || done_cnt - base != 8) begin
      n_err++;
      $display("FAIL catch_up: got debt %0d refs %0d want 0/8", bif.debt, done_cnt - base);
    end
  endtask

  task automatic test_overflow();
    bif.enable = 1'b1; bif.pullin_en = 1'b0; bif.bus_idle = 1'b0; bif.banks_open = '0;
    ack_en = 1'b0;
    do_reset();
    wait_cyc(rel + 9 * T_REFI);
    n_cmp++;
    if (bif.debt !== 5'sd9 || bif.err_overflow !== 1'b0) begin
      n_err++;
      $display("FAIL debt9: got debt %0d err %b want 9/0", bif.debt, bif.err_overflow);
    end
    wait_cyc(rel + 10 * T_REFI);
    n_cmp++;
    if (bif.debt !== 5'sd9 || bif.err_overflow !== 1'b1) begin
      n_err++;
      $display("FAIL overflow: got debt %0d err %b want 9/1", bif.debt, bif.err_overflow);
    end
    ack_en = 1'b1;
  endtask

  task automatic test_pullin();
    bif.enable = 1'b1; bif.pullin_en = 1'b1; bif.bus_idle = 1'b1; bif.banks_open = '0;
    do_reset();
    wait_cyc(rel + T_REFI - 1);
    n_cmp++;
    if (bif.debt !== -5'sd8 || bif.hold_traffic !== 1'b0) begin
      n_err++;
      $display("FAIL pullin_limit: got debt %0d hold %b want -8/0", bif.debt, bif.hold_traffic);
    end
    wait_cyc(rel + T_REFI + 1);
    n_cmp++;
    if (bif.debt !== -5'sd7 || bif.hold_traffic !== 1'b1) begin
      n_err++;
      $display("FAIL pullin_resume: got debt %0d hold %b want -7/1", bif.debt, bif.hold_traffic);
    end
  endtask

  task automatic test_enable();
    int base;
    bif.enable = 1'b0; bif.pullin_en = 1'b1; bif.bus_idle = 1'b1; bif.banks_open = '0;
    do_reset();
    wait_cyc(rel + 20);
    n_cmp++;
    if (bif.hold_traffic !== 1'b0) begin
      n_err++; $display("FAIL enable_block: got hold %b want 0", bif.hold_traffic);
    end
    base = done_cnt;
    bif.enable = 1'b1;
    wait_cyc(rel + 21);
    bif.enable = 1'b0;
    for (int i = 0; i < 40 && bif.hold_traffic === 1'b1; i++) @(negedge sys_clk);
    repeat (10) @(negedge sys_clk);
    n_cmp++;
    if (done_cnt - base != 1 || bif.debt !== -5'sd1 || bif.hold_traffic !== 1'b0) begin
      n_err++;
      $display("FAIL enable_drop: got refs %0d debt %0d hold %b want 1/-1/0",
               done_cnt - base, bif.debt, bif.hold_traffic);
    end
  endtask

  task automatic test_precharge();
    int unsigned p;
    bif.enable = 1'b1; bif.pullin_en = 1'b1; bif.bus_idle = 1'b1; bif.banks_open = 16'h0041;
    pre_delay = 3;
    do_reset();
    for (int i = 0; i < 20 && bif.pre_req !== 1'b1; i++) @(negedge sys_clk);
    p = cyc;
    n_cmp++;
    if (bif.pre_req !== 1'b1) begin
      n_err++; $display("FAIL pre_req_rise: got %b want 1", bif.pre_req);
    end
    bif.pullin_en = 1'b0;
    wait_cyc(p + 3);
    n_cmp++;
    if (bif.pre_req !== 1'b1) begin
      n_err++; $display("FAIL pre_hold: got %b want 1", bif.pre_req);
    end
    wait_cyc(p + 4);
    n_cmp++;
    if (bif.pre_req !== 1'b0 || bif.ref_req !== 1'b0) begin
      n_err++;
      $display("FAIL pre_drop: got pre %b ref %b want 0/0", bif.pre_req, bif.ref_req);
    end
    for (int i = 0; i < 40 && bif.hold_traffic === 1'b1; i++) @(negedge sys_clk);
    n_cmp++;
    if (bif.hold_traffic !== 1'b0 || bif.debt !== -5'sd1) begin
      n_err++;
      $display("FAIL prech_seq_end: got hold %b debt %0d want 0/-1", bif.hold_traffic, bif.debt);
    end
    pre_delay = 0;
  endtask

  task automatic test_tick_vs_done();
    bif.enable = 1'b1; bif.pullin_en = 1'b1; bif.bus_idle = 1'b0; bif.banks_open = '0;
    do_reset();
    wait_cyc(rel + T_REFI - 3 - T_RFC);
    bif.bus_idle = 1'b1;
    wait_cyc(rel + T_REFI - 1);
    bif.bus_idle = 1'b0;
    n_cmp++;
    if (bif.refresh_done !== 1'b1 || bif.debt !== 5'sd0) begin
      n_err++;
      $display("FAIL coincide_setup: got done %b debt %0d want 1/0", bif.refresh_done, bif.debt);
    end
    wait_cyc(rel + T_REFI);
    n_cmp++;
    if (bif.debt !== 5'sd0) begin
      n_err++; $display("FAIL coincide_debt: got %0d want 0", bif.debt);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    bif.enable = 1'b1; bif.pullin_en = 1'b1; bif.bus_idle = 1'b1; bif.banks_open = '0;
    do_reset();
    wait_cyc(rel + 16);
    n_cmp++;
    if (bif.debt !== -5'sd1 || bif.hold_traffic !== 1'b1) begin
      n_err++;
      $display("FAIL mid_setup: got debt %0d hold %b want -1/1", bif.debt, bif.hold_traffic);
    end
    base = done_cnt;
    #2;
    sys_rst_n = 1'b0;
    done_q.delete();
    rp_q.delete();
    #1;
    n_cmp++;
    if ({bif.pre_req, bif.ref_req, bif.hold_traffic, bif.urgent, bif.refresh_done,
         bif.err_overflow} !== 6'b0 || bif.debt !== 5'sd0) begin
      n_err++;
      $display("FAIL async_reset: got outs %b debt %0d want 000000/0", {bif.pre_req,
               bif.ref_req, bif.hold_traffic, bif.urgent, bif.refresh_done,
               bif.err_overflow}, bif.debt);
    end
    bif.pullin_en = 1'b0;
    bif.bus_idle  = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (12) @(negedge sys_clk);
    n_cmp++;
    if (done_cnt != base || bif.hold_traffic !== 1'b0) begin
      n_err++;
      $display("FAIL abort_no_done: got pulses %0d hold %b want 0/0", done_cnt - base,
               bif.hold_traffic);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; done_cnt = 0; cyc = 0; rel = 0;
    ack_en = 1'b1; pre_delay = 0;
    sys_rst_n = 1'b0;
    bif.enable = 1'b0; bif.pullin_en = 1'b0; bif.bus_idle = 1'b0; bif.banks_open = '0;
    bif.pre_ack = 1'b0; bif.ref_ack = 1'b0;
    test_reset();
    test_first_tick();
    test_postpone();
    test_overflow();
    test_pullin();
    test_enable();
    test_precharge();
    test_tick_vs_done();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
